// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between an instruction-fetch and a data requester.
// Data normally has priority; a fetch that keeps losing is promoted once its starve count saturates.
module mem_port_arbiter #(
  parameter int StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
  localparam logic [CW-1:0] LIM = CW'(StarveLimit);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;

  state_e          state_q, state_d;
  logic            own_if_q, own_if_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
  logic            if_win, d_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      own_if_q <= 1'b0;
      drop_q   <= 1'b0;
      starve_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_if_q <= own_if_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    own_if_d = own_if_q;
    drop_d   = drop_q;
    starve_d = starve_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if_win   = 1'b0;
    d_win    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i && starve_q >= LIM) if_win = 1'b1;
        else if (d_req_i)                d_win  = 1'b1;
        else if (if_req_i)               if_win = 1'b1;
        if (if_win || d_win) begin
          state_d  = WAIT_GNT;
          own_if_d = if_win;
          addr_d   = if_win ? if_addr_i : d_addr_i;
          we_d     = d_win & d_we_i;
          be_d     = if_win ? 4'hF : d_be_i;
          wdata_d  = if_win ? 32'h0 : d_wdata_i;
        end
      end
      WAIT_GNT: if (mem_gnt_i)    state_d = WAIT_RSP;
      WAIT_RSP: if (mem_rvalid_i) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
    // A fetch that is waiting but not being served ages toward forced priority.
    if (if_win)
      starve_d = '0;
    else if (if_req_i && !(own_if_q && state_q != IDLE) && starve_q < LIM)
      starve_d = starve_q + 1'b1;
    if (state_q == WAIT_RSP && mem_rvalid_i)
      drop_d = 1'b0;
    else if (if_flush_i && own_if_q && state_q != IDLE)
      drop_d = 1'b1;
  end

  // Outputs are forced low while reset is asserted, whatever the stale state is.
  logic live, gnt_ev, rsp_ev;
  assign live   = !rst_i;
  assign gnt_ev = live && state_q == WAIT_GNT && mem_gnt_i;
  assign rsp_ev = live && state_q == WAIT_RSP && mem_rvalid_i;

  assign mem_req_o   = live && state_q == WAIT_GNT;
  assign mem_we_o    = live & we_q;
  assign mem_be_o    = live ? be_q    : 4'h0;
  assign mem_addr_o  = live ? addr_q  : 32'h0;
  assign mem_wdata_o = live ? wdata_q : 32'h0;

  assign if_gnt_o    = gnt_ev && own_if_q;
  assign d_gnt_o     = gnt_ev && !own_if_q;
  assign if_rvalid_o = rsp_ev && own_if_q && !drop_q && !if_flush_i;
  assign d_rvalid_o  = rsp_ev && !own_if_q;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
  assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : 32'h0;

endmodule
